// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with direct/set/clear/toggle access and a
// hardware-timed auto-clearing pulse engine with maskable completion irq.
module pio_out_pulse #(
  parameter int unsigned            WIDTH           = 8,
  parameter int unsigned            CNT_W           = 16,
  parameter logic [WIDTH-1:0]       RESET_VALUE     = '0,
  parameter logic [CNT_W-1:0]       PULSE_LEN_RESET = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    A_DATA      = 3'd0,
    A_PULSE_LEN = 3'd1,
    A_PULSE     = 3'd2,
    A_STATUS    = 3'd3,
    A_SET       = 3'd4,
    A_CLEAR     = 3'd5,
    A_TOGGLE    = 3'd6,
    A_RSVD      = 3'd7
  } reg_addr_e;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             pulse_wr;
  logic             expire;
  logic [CNT_W-1:0] load_len;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  assign wr       = chipselect & ~write_n;
  assign wd       = writedata[WIDTH-1:0];
  assign pulse_wr = wr && (address == A_PULSE) && (wd != '0);
  assign load_len = (len_q == '0) ? CNT_W'(1) : len_q;

  // Next-state: pulse engine first, then the CPU operation on its result,
  // so a SET on the expiry edge wins and a done-clear loses to expiry.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    len_d    = len_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    expire   = 1'b0;

    if (busy_q && !pulse_wr) begin
      if (count_q == CNT_W'(1)) begin
        expire = 1'b1;
        data_d = data_q & ~mask_q;
        mask_d = '0;
        busy_d = 1'b0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    if (wr) begin
      case (address)
        A_DATA:      data_d = wd;
        A_PULSE_LEN: len_d  = writedata[CNT_W-1:0];
        A_PULSE: begin
          if (wd != '0) begin
            data_d  = data_d | wd;
            mask_d  = mask_q | wd;
            count_d = load_len;
            busy_d  = 1'b1;
          end
        end
        A_STATUS: begin
          if (writedata[1]) done_d = 1'b0;
          irq_en_d = writedata[2];
        end
        A_SET:    data_d = data_d | wd;
        A_CLEAR:  data_d = data_d & ~wd;
        A_TOGGLE: data_d = data_d ^ wd;
        default:  ;
      endcase
    end

    if (expire) done_d = 1'b1;

    irq_d = done_q & irq_en_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      len_q    <= PULSE_LEN_RESET;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  // Combinational read mux, zero wait states, no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:      readdata[WIDTH-1:0] = data_q;
      A_PULSE_LEN: readdata[CNT_W-1:0] = len_q;
      A_PULSE:     readdata[WIDTH-1:0] = mask_q;
      A_STATUS:    readdata[2:0]       = {irq_en_q, done_q, busy_q};
      default:     readdata = '0;
    endcase
  end

  assign out_port = data_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Scoreboard bench for pio_out_pulse: driver pushes expected responses,
// a negedge monitor pops and compares them.
module tb_pio_out_pulse;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  localparam int C_RD  = 1;
  localparam int C_OUT = 2;
  localparam int C_IRQ = 4;
  localparam int C_ALL = 7;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [7:0]  out;
    logic        irq;
    int          flags;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  pio_out_pulse #(
    .WIDTH(8),
    .CNT_W(16),
    .RESET_VALUE(8'hA5),
    .PULSE_LEN_RESET(16'd1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: pops every pending expectation on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if ((e.flags & C_RD) != 0 && readdata !== e.rd) begin
          miscompares++;
          $display("FAIL %s readdata: got %08h want %08h", e.name, readdata, e.rd);
        end
        if ((e.flags & C_OUT) != 0 && out_port !== e.out) begin
          miscompares++;
          $display("FAIL %s out_port: got %02h want %02h", e.name, out_port, e.out);
        end
        if ((e.flags & C_IRQ) != 0 && irq !== e.irq) begin
          miscompares++;
          $display("FAIL %s irq: got %0b want %0b", e.name, irq, e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Queue one expectation for the upcoming falling edge; at most one per cycle.
  task automatic chk(input string name, input logic [2:0] a, input logic [31:0] rd,
                     input logic [7:0] out, input logic irq_exp, input int flags);
    exp_t e;
    address = a;
    e.name = name; e.rd = rd; e.out = out; e.irq = irq_exp; e.flags = flags;
    q.push_back(e);
    @(negedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    idle(); idle();
    chk("reset", 3'd3, 32'h0, 8'hA5, 1'b0, C_ALL);
    reset_n = 1'b1;
    idle();
    chk("reset_len", 3'd1, 32'h1, 8'hA5, 1'b0, C_ALL);

    // Direct access ops
    wr(3'd4, 32'h0F); chk("set",    3'd0, 32'hAF, 8'hAF, 1'b0, C_RD | C_OUT);
    wr(3'd5, 32'h81); chk("clear",  3'd0, 32'h2E, 8'h2E, 1'b0, C_RD | C_OUT);
    wr(3'd6, 32'hFF); chk("toggle", 3'd0, 32'hD1, 8'hD1, 1'b0, C_RD | C_OUT);
    wr(3'd0, 32'h3C); chk("data",   3'd0, 32'h3C, 8'h3C, 1'b0, C_RD | C_OUT);
    idle();           chk("rd_set", 3'd4, 32'h0,  8'h3C, 1'b0, C_RD | C_OUT);

    // 5-cycle pulse with irq
    wr(3'd0, 32'h0); wr(3'd1, 32'd5); wr(3'd3, 32'h4);
    wr(3'd2, 32'h03);
    for (int i = 0; i < 5; i++) begin
      chk("p5_high", 3'd3, 32'h5, 8'h03, 1'b0, C_ALL);
      idle();
    end
    chk("p5_fall", 3'd3, 32'h6, 8'h00, 1'b0, C_ALL);
    idle();
    chk("p5_irq",  3'd3, 32'h6, 8'h00, 1'b1, C_ALL);
    wr(3'd3, 32'h2);
    chk("p5_clr",  3'd3, 32'h0, 8'h00, 1'b1, C_ALL);
    idle();
    chk("p5_irq_off", 3'd3, 32'h0, 8'h00, 1'b0, C_ALL);

    // Zero length acts as one cycle
    wr(3'd1, 32'd0); wr(3'd2, 32'h80);
    chk("p0_high", 3'd3, 32'h1, 8'h80, 1'b0, C_ALL);
    idle();
    chk("p0_fall", 3'd3, 32'h2, 8'h00, 1'b0, C_ALL);
    wr(3'd3, 32'h2);

    // Retrigger
    wr(3'd1, 32'd10); wr(3'd2, 32'h01);
    for (int i = 0; i < 3; i++) begin
      chk("rt_first", 3'd2, 32'h01, 8'h01, 1'b0, C_RD | C_OUT);
      idle();
    end
    chk("rt_first", 3'd2, 32'h01, 8'h01, 1'b0, C_RD | C_OUT);
    wr(3'd2, 32'h02);
    for (int i = 0; i < 10; i++) begin
      chk("rt_both", 3'd2, 32'h03, 8'h03, 1'b0, C_RD | C_OUT);
      idle();
    end
    chk("rt_fall", 3'd2, 32'h00, 8'h00, 1'b0, C_RD | C_OUT);
    idle();
    chk("rt_done", 3'd3, 32'h2, 8'h00, 1'b0, C_RD | C_OUT);
    wr(3'd3, 32'h2);

    // SET on the expiry edge wins
    wr(3'd1, 32'd3); wr(3'd2, 32'h01);
    chk("se_high", 3'd3, 32'h1, 8'h01, 1'b0, C_RD | C_OUT);
    idle(); idle();
    wr(3'd4, 32'h01);
    chk("se_set", 3'd3, 32'h2, 8'h01, 1'b0, C_RD | C_OUT);
    wr(3'd3, 32'h2);
    chk("se_clr", 3'd3, 32'h0, 8'h01, 1'b0, C_RD | C_OUT);

    // done-clear on the expiry edge loses
    wr(3'd2, 32'h01);
    idle(); idle();
    wr(3'd3, 32'h2);
    chk("dc_set_wins", 3'd3, 32'h2, 8'h00, 1'b0, C_RD | C_OUT);
    wr(3'd3, 32'h2);

    // CLEAR mid-pulse, PULSE_LEN write while busy
    wr(3'd2, 32'h01);
    chk("cm_high", 3'd3, 32'h1, 8'h01, 1'b0, C_RD | C_OUT);
    wr(3'd1, 32'd50);
    wr(3'd5, 32'h01);
    chk("cm_low", 3'd3, 32'h1, 8'h00, 1'b0, C_RD | C_OUT);
    idle();
    chk("cm_done", 3'd3, 32'h2, 8'h00, 1'b0, C_RD | C_OUT);
    idle();
    chk("cm_len", 3'd1, 32'd50, 8'h00, 1'b0, C_RD | C_OUT);
    wr(3'd3, 32'h2);

    // Reset mid-pulse
    wr(3'd1, 32'd100); wr(3'd3, 32'h4); wr(3'd2, 32'hFF);
    chk("rs_high", 3'd3, 32'h5, 8'hFF, 1'b0, C_ALL);
    for (int i = 0; i < 19; i++) idle();
    reset_n = 1'b0;
    #1;
    chk("rs_async", 3'd3, 32'h0, 8'hA5, 1'b0, C_ALL);
    idle();
    reset_n = 1'b1;
    idle();
    chk("rs_after", 3'd3, 32'h0, 8'hA5, 1'b0, C_ALL);
    for (int i = 0; i < 100; i++) idle();
    chk("rs_no_irq", 3'd3, 32'h0, 8'hA5, 1'b0, C_ALL);

    idle(); idle();
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
